wb_commit: RTL and testbench

//  Writeback commit stage, directly downstream of the EXE/WB pipeline registers.
//  - Takes up to four per-cycle results (ALU, LD, MUL, DIV lanes), each a 4-bit Rd plus 32-bit data.
//  - Buffers one result per lane and round-robin arbitrates them onto the register file's single write port.
//  - Back-pressures each lane and publishes a pending-write scoreboard for the hazard unit.

---
 rtl/wb_pkg.sv | 27 ++
 rtl/wb_commit_if.sv | 31 +++
 rtl/rr_arbiter4.sv | 30 +++
 rtl/wb_commit.sv | 134 +++++++++++++
 tb/tb_wb_commit.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/wb_pkg.sv
// Shared constants and types for the writeback commit stage.
package wb_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned RD_W    = 4;
  localparam int unsigned N_LANES = 4;
  localparam int unsigned N_REGS  = 1 << RD_W;

  localparam int unsigned LANE_ALU = 3;
  localparam int unsigned LANE_LD  = 2;
  localparam int unsigned LANE_MUL = 1;
  localparam int unsigned LANE_DIV = 0;

  typedef struct packed {
    logic              v;
    logic [RD_W-1:0]   rd;
    logic [DATA_W-1:0] data;
  } wb_slot_t;

  function automatic logic [N_REGS-1:0] rd_onehot(input logic [RD_W-1:0] rd);
    logic [N_REGS-1:0] oh;
    oh     = '0;
    oh[rd] = 1'b1;
    return oh;
  endfunction

endpackage

// File: rtl/wb_commit_if.sv
// Lane results, back-pressure and register-file write port of the commit stage.
interface wb_commit_if
  import wb_pkg::*;
;

  logic [N_LANES-1:0] in_valid;
  logic [RD_W-1:0]    alu_rd;
  logic [DATA_W-1:0]  alu_wb;
  logic [RD_W-1:0]    ld_rd;
  logic [DATA_W-1:0]  ld_wb;
  logic [RD_W-1:0]    mul_rd;
  logic [DATA_W-1:0]  mul_wb;
  logic [RD_W-1:0]    div_rd;
  logic [DATA_W-1:0]  div_wb;
  logic [N_LANES-1:0] stall;
  logic               rf_we;
  logic [RD_W-1:0]    rf_waddr;
  logic [DATA_W-1:0]  rf_wdata;
  logic [N_REGS-1:0]  pending_mask;

  modport master (
    output in_valid, alu_rd, alu_wb, ld_rd, ld_wb, mul_rd, mul_wb, div_rd, div_wb,
    input  stall, rf_we, rf_waddr, rf_wdata, pending_mask
  );

  modport slave (
    input  in_valid, alu_rd, alu_wb, ld_rd, ld_wb, mul_rd, mul_wb, div_rd, div_wb,
    output stall, rf_we, rf_waddr, rf_wdata, pending_mask
  );

endinterface

// File: rtl/rr_arbiter4.sv
// Four-way round-robin arbiter; searches downward starting one below the last grant.
module rr_arbiter4
  import wb_pkg::*;
(
  input  logic [N_LANES-1:0] req_i,
  input  logic [1:0]         rr_ptr_i,
  output logic [N_LANES-1:0] gnt_o,
  output logic [1:0]         gnt_idx_o,
  output logic               gnt_valid_o
);

  logic [1:0] cand;

  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    cand        = '0;
    // k = 4 wraps to rr_ptr itself, so the last granted lane is considered last.
    for (int k = 1; k <= 4; k++) begin
      cand = rr_ptr_i - 2'(k);
      if (!gnt_valid_o && req_i[cand]) begin
        gnt_valid_o = 1'b1;
        gnt_idx_o   = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_commit.sv
// Buffers one result per execution lane and commits them one per cycle to the register file.
module wb_commit
  import wb_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  wb_commit_if.slave lane_if
);

  wb_slot_t            slot_q [N_LANES];
  wb_slot_t            slot_d [N_LANES];
  logic [RD_W-1:0]     in_rd  [N_LANES];
  logic [DATA_W-1:0]   in_data[N_LANES];

  logic [N_LANES-1:0]  req;
  logic [N_LANES-1:0]  gnt;
  logic [N_LANES-1:0]  stall;
  logic [N_LANES-1:0]  accept;
  logic [N_LANES-1:0]  load;
  logic [1:0]          gnt_idx;
  logic                gnt_valid;
  logic [1:0]          rr_ptr_q, rr_ptr_d;

  logic                rf_we_q;
  logic [RD_W-1:0]     rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_wdata_q, rf_wdata_d;
  logic [N_REGS-1:0]   pending;

  assign in_rd[LANE_ALU]   = lane_if.alu_rd;
  assign in_rd[LANE_LD]    = lane_if.ld_rd;
  assign in_rd[LANE_MUL]   = lane_if.mul_rd;
  assign in_rd[LANE_DIV]   = lane_if.div_rd;
  assign in_data[LANE_ALU] = lane_if.alu_wb;
  assign in_data[LANE_LD]  = lane_if.ld_wb;
  assign in_data[LANE_MUL] = lane_if.mul_wb;
  assign in_data[LANE_DIV] = lane_if.div_wb;

  always_comb begin
    req = '0;
    for (int i = 0; i < N_LANES; i++) begin
      req[i] = slot_q[i].v;
    end
  end

  rr_arbiter4 u_arb (
    .req_i      (req),
    .rr_ptr_i   (rr_ptr_q),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid)
  );

  assign stall  = req & ~gnt;
  assign accept = lane_if.in_valid & ~stall;

  // Same-cycle duplicate Rd: the higher lane wins and the lower is dropped.
  always_comb begin
    load = accept;
    for (int i = 0; i < N_LANES; i++) begin
      for (int j = i + 1; j < N_LANES; j++) begin
        if (accept[i] && accept[j] && (in_rd[i] == in_rd[j])) begin
          load[i] = 1'b0;
        end
      end
    end
  end

  always_comb begin
    for (int j = 0; j < N_LANES; j++) begin
      slot_d[j] = slot_q[j];
      if (gnt[j]) begin
        slot_d[j].v = 1'b0;
      end
      // WAW kill: a newer result for the same register makes an unwritten older one dead.
      for (int i = 0; i < N_LANES; i++) begin
        if ((i != j) && accept[i] && slot_q[j].v && !gnt[j] && (slot_q[j].rd == in_rd[i])) begin
          slot_d[j].v = 1'b0;
        end
      end
      if (load[j]) begin
        slot_d[j].v    = 1'b1;
        slot_d[j].rd   = in_rd[j];
        slot_d[j].data = in_data[j];
      end
    end
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (gnt_valid) begin
      rr_ptr_d   = gnt_idx;
      rf_waddr_d = slot_q[gnt_idx].rd;
      rf_wdata_d = slot_q[gnt_idx].data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N_LANES; i++) begin
        slot_q[i] <= '0;
      end
      rr_ptr_q   <= '0;
      rf_we_q    <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      for (int i = 0; i < N_LANES; i++) begin
        slot_q[i] <= slot_d[i];
      end
      rr_ptr_q   <= rr_ptr_d;
      rf_we_q    <= gnt_valid;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_comb begin
    pending = '0;
    for (int i = 0; i < N_LANES; i++) begin
      if (slot_q[i].v) begin
        pending = pending | rd_onehot(slot_q[i].rd);
      end
    end
  end

  assign lane_if.stall        = stall;
  assign lane_if.rf_we        = rf_we_q;
  assign lane_if.rf_waddr     = rf_waddr_q;
  assign lane_if.rf_wdata     = rf_wdata_q;
  assign lane_if.pending_mask = pending;

endmodule

// File: tb/tb_wb_commit.sv
// Directed bench for wb_commit: single-lane vector table plus multi-cycle arbitration sequences.
module tb_wb_commit;
  import wb_pkg::*;

  logic clk;
  logic rst;

  wb_commit_if bus ();

  wb_commit dut (
    .clk    (clk),
    .rst    (rst),
    .lane_if(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors;
  int checks;
  logic [35:0] wlog[$];

  // Every register-file write, captured just after the edge that makes it visible.
  always @(posedge clk) begin
    #1;
    if (bus.rf_we === 1'b1) wlog.push_back({bus.rf_waddr, bus.rf_wdata});
  end

  typedef struct {
    logic [3:0]  valid;
    logic [3:0]  rd;
    logic [31:0] data;
    logic [15:0] exp_pend;
    logic [3:0]  exp_waddr;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_log(input string name, input logic [35:0] exp[$]);
    chk({name, "_count"}, 64'(wlog.size()), 64'(exp.size()));
    for (int k = 0; k < exp.size(); k++) begin
      chk($sformatf("%s_w%0d", name, k),
          (k < wlog.size()) ? {28'd0, wlog[k]} : 64'hBAD0_0000_0000_0000, {28'd0, exp[k]});
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic set_lanes(input logic [3:0] a_rd, input logic [31:0] a_d,
                           input logic [3:0] l_rd, input logic [31:0] l_d,
                           input logic [3:0] m_rd, input logic [31:0] m_d,
                           input logic [3:0] d_rd, input logic [31:0] d_d);
    bus.alu_rd = a_rd; bus.alu_wb = a_d;
    bus.ld_rd  = l_rd; bus.ld_wb  = l_d;
    bus.mul_rd = m_rd; bus.mul_wb = m_d;
    bus.div_rd = d_rd; bus.div_wb = d_d;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.in_valid = '0;
    step();
    step();
    rst = 1'b0;
    wlog.delete();
  endtask

  initial begin
    errors = 0;
    checks = 0;
    rst = 1'b1;
    bus.in_valid = '0;
    set_lanes(4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0, 4'd0, 32'd0);

    vecs[0] = '{valid: 4'b1000, rd: 4'd5,  data: 32'hDEAD_BEEF, exp_pend: 16'h0020,
                exp_waddr: 4'd5,  exp_wdata: 32'hDEAD_BEEF};
    vecs[1] = '{valid: 4'b0100, rd: 4'd0,  data: 32'h0000_0001, exp_pend: 16'h0001,
                exp_waddr: 4'd0,  exp_wdata: 32'h0000_0001};
    vecs[2] = '{valid: 4'b0010, rd: 4'd15, data: 32'hFFFF_FFFF, exp_pend: 16'h8000,
                exp_waddr: 4'd15, exp_wdata: 32'hFFFF_FFFF};
    vecs[3] = '{valid: 4'b0001, rd: 4'd10, data: 32'h1234_5678, exp_pend: 16'h0400,
                exp_waddr: 4'd10, exp_wdata: 32'h1234_5678};

    do_reset();
    chk("rst_we",    64'(bus.rf_we),        64'd0);
    chk("rst_waddr", 64'(bus.rf_waddr),     64'd0);
    chk("rst_wdata", 64'(bus.rf_wdata),     64'd0);
    chk("rst_pend",  64'(bus.pending_mask), 64'd0);
    chk("rst_stall", 64'(bus.stall),        64'd0);

    // Single-lane results: two-edge latency, no stall, pending bit while buffered.
    for (int v = 0; v < 4; v++) begin
      do_reset();
      set_lanes(vecs[v].rd, vecs[v].data, vecs[v].rd, vecs[v].data,
                vecs[v].rd, vecs[v].data, vecs[v].rd, vecs[v].data);
      bus.in_valid = vecs[v].valid;
      step();
      bus.in_valid = '0;
      chk($sformatf("v%0d_pend", v),  64'(bus.pending_mask), 64'(vecs[v].exp_pend));
      chk($sformatf("v%0d_stall", v), 64'(bus.stall), 64'd0);
      chk($sformatf("v%0d_we0", v),   64'(bus.rf_we), 64'd0);
      step();
      chk($sformatf("v%0d_we", v),    64'(bus.rf_we), 64'd1);
      chk($sformatf("v%0d_waddr", v), 64'(bus.rf_waddr), 64'(vecs[v].exp_waddr));
      chk($sformatf("v%0d_wdata", v), 64'(bus.rf_wdata), 64'(vecs[v].exp_wdata));
      chk($sformatf("v%0d_pend0", v), 64'(bus.pending_mask), 64'd0);
      step();
      chk($sformatf("v%0d_we_off", v), 64'(bus.rf_we), 64'd0);
    end

    // All four lanes at once: ALU, LD, MUL, DIV order, pending clears bit by bit.
    begin
      logic [3:0]  ea[4];
      logic [15:0] ep[4];
      ea = '{4'd1, 4'd2, 4'd3, 4'd4};
      ep = '{16'h001C, 16'h0018, 16'h0010, 16'h0000};
      do_reset();
      set_lanes(4'd1, 32'hA1, 4'd2, 32'hA2, 4'd3, 32'hA3, 4'd4, 32'hA4);
      bus.in_valid = 4'b1111;
      step();
      bus.in_valid = '0;
      chk("all_pend",  64'(bus.pending_mask), 64'h001E);
      chk("all_stall", 64'(bus.stall),        64'b0111);
      for (int k = 0; k < 4; k++) begin
        step();
        chk($sformatf("all_we%0d", k),    64'(bus.rf_we),        64'd1);
        chk($sformatf("all_waddr%0d", k), 64'(bus.rf_waddr),     64'(ea[k]));
        chk($sformatf("all_pend%0d", k),  64'(bus.pending_mask), 64'(ep[k]));
      end
      step();
      chk("all_idle", 64'(bus.rf_we), 64'd0);
    end

    // WAW kill: DIV R7=1 waits, ALU re-issues R7=2; only the newer value is written.
    begin
      logic [35:0] exp[$];
      do_reset();
      set_lanes(4'd10, 32'hA, 4'd11, 32'hB, 4'd12, 32'hC, 4'd7, 32'h1);
      bus.in_valid = 4'b1111;
      step();
      bus.alu_rd = 4'd7;
      bus.alu_wb = 32'h2;
      bus.in_valid = 4'b1000;
      chk("waw_alu_free", 64'(bus.stall[LANE_ALU]), 64'd0);
      step();
      bus.in_valid = '0;
      chk("waw_pend", 64'(bus.pending_mask), 64'h1880);
      repeat (5) step();
      exp = '{{4'd10, 32'hA}, {4'd11, 32'hB}, {4'd12, 32'hC}, {4'd7, 32'h2}};
      chk_log("waw", exp);
    end

    // LD back-pressure: second item held while stalled, nothing lost.
    begin
      logic [35:0] exp[$];
      do_reset();
      set_lanes(4'd1, 32'h11, 4'd2, 32'h22, 4'd0, 32'h0, 4'd0, 32'h0);
      bus.in_valid = 4'b1100;
      step();
      bus.ld_rd = 4'd3;
      bus.ld_wb = 32'h33;
      bus.in_valid = 4'b0100;
      chk("bp_stall_hi", 64'(bus.stall[LANE_LD]), 64'd1);
      step();
      chk("bp_stall_lo", 64'(bus.stall[LANE_LD]), 64'd0);
      step();
      bus.in_valid = '0;
      chk("bp_pend", 64'(bus.pending_mask), 64'h0008);
      repeat (3) step();
      exp = '{{4'd1, 32'h11}, {4'd2, 32'h22}, {4'd3, 32'h33}};
      chk_log("bp", exp);
    end

    // Reset with three slots full discards everything.
    begin
      logic [35:0] exp[$];
      do_reset();
      set_lanes(4'd1, 32'h51, 4'd2, 32'h52, 4'd3, 32'h53, 4'd0, 32'h0);
      bus.in_valid = 4'b1110;
      step();
      bus.in_valid = '0;
      chk("mrst_pend_pre", 64'(bus.pending_mask), 64'h000E);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("mrst_we",    64'(bus.rf_we),        64'd0);
      chk("mrst_pend",  64'(bus.pending_mask), 64'd0);
      chk("mrst_stall", 64'(bus.stall),        64'd0);
      repeat (4) step();
      exp = {};
      chk_log("mrst", exp);
    end

    // Same-cycle duplicate Rd: ALU beats MUL.
    begin
      logic [35:0] exp[$];
      do_reset();
      set_lanes(4'd9, 32'h111, 4'd0, 32'h0, 4'd9, 32'h222, 4'd0, 32'h0);
      bus.in_valid = 4'b1010;
      step();
      bus.in_valid = '0;
      chk("dup_pend",  64'(bus.pending_mask), 64'h0200);
      chk("dup_stall", 64'(bus.stall),        64'd0);
      repeat (3) step();
      exp = '{{4'd9, 32'h111}};
      chk_log("dup", exp);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
